// File: rtl/spi_px_master_pkg.sv
// Shared constants, FSM state type and width helper for the SPI pixel initiator.
package spi_px_master_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int SPI_CLK_DIV    = 2;
  localparam int SPI_CS_GAP     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    GAP    = 3'd4
  } spi_master_state_t;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/spi_px_master_clk_div.sv
// Half-period tick counter: counts while enabled, ticks on the last cycle of a phase and wraps.
module spi_master_clk_div
  import spi_px_master_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = clog2_min1(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_px_master.sv
// Mode-0 MSB-first SPI initiator: one pixel out on SDI, one result in from SDO per frame.
// Define SPI_MASTER_LOOPBACK_EN to add loopback_i (sample SDI instead of SDO).
module spi_px_master
  import spi_px_master_pkg::*;
#(
  parameter int PIXEL_BITS = MAX_PIXEL_BITS,
  parameter int CLK_DIV    = SPI_CLK_DIV,
  parameter int CS_GAP     = SPI_CS_GAP
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic [PIXEL_BITS-1:0] tx_px_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [PIXEL_BITS-1:0] rx_px_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_o,
  output logic                  spi_sdi_o,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  input  logic                  spi_sdo_i
);

  localparam int BW = $clog2(PIXEL_BITS + 1);
  localparam int GW = clog2_min1(CS_GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(PIXEL_BITS);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_master_state_t     state_q, state_d;
  logic [PIXEL_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_px_q, rx_px_d;
  logic [PIXEL_BITS-1:0] tx_next;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic rx_valid_q, rx_valid_d, sck_q, sck_d, cs_q, cs_d, sdi_q, sdi_d, busy_q, busy_d;
  logic tick, sample;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = loopback_i ? sdi_q : spi_sdo_i;
`else
  assign sample = spi_sdo_i;
`endif

  spi_master_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .en_i    (state_q == LEAD || state_q == SCK_HI || state_q == SCK_LO),
    .clr_i   (state_q == IDLE),
    .tick_o  (tick)
  );

  assign tx_next = tx_sh_q << 1;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_px_d    = rx_px_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    cs_d       = cs_q;
    sdi_d      = sdi_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: if (tx_valid_i) begin
        state_d   = LEAD;
        tx_sh_d   = tx_px_i;
        rx_sh_d   = '0;
        bit_cnt_d = '0;
        cs_d      = 1'b0;
        sdi_d     = tx_px_i[PIXEL_BITS-1];
        busy_d    = 1'b1;
      end
      LEAD: if (tick) begin
        state_d = SCK_HI;
        sck_d   = 1'b1;
      end
      // Sample on the last high cycle so the slave's SDO change at SCK fall is never raced.
      SCK_HI: if (tick) begin
        state_d   = SCK_LO;
        sck_d     = 1'b0;
        rx_sh_d   = PIXEL_BITS'({rx_sh_q, sample});
        tx_sh_d   = tx_next;
        sdi_d     = tx_next[PIXEL_BITS-1];
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      SCK_LO: if (tick) begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d    = GAP;
          cs_d       = 1'b1;
          sdi_d      = 1'b0;
          rx_px_d    = rx_sh_q;
          rx_valid_d = 1'b1;
          gap_cnt_d  = '0;
        end else begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_px_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      sdi_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_px_q    <= rx_px_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      sdi_q      <= sdi_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready_o = (state_q == IDLE);
  assign rx_px_o    = rx_px_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign spi_sck_o  = sck_q;
  assign spi_cs_o   = cs_q;
  assign spi_sdi_o  = sdi_q;

endmodule
